// File: rtl/port_bus_master_pkg.sv
// Shared types for the port bus master: FSM state encoding, the queued
// command record and the default command queue depth.
package port_bus_master_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef struct packed {
    logic       write;
    logic       is_const;
    logic [7:0] port;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/port_bus_master_if.sv
// Command/response handshake and responder bus of the port bus master.
// master: the bus master side (port_bus_master).
// slave : the command issuer / responder side (testbench or system).
interface port_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_const;
  logic [7:0] req_port;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic       irq_event;
  logic       busy;

  modport master (
    input  req_valid, req_write, req_const, req_port, req_data, in_port, interrupt,
    output req_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, k_write_strobe, read_strobe, interrupt_ack, irq_event, busy
  );

  modport slave (
    output req_valid, req_write, req_const, req_port, req_data, in_port, interrupt,
    input  req_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, k_write_strobe, read_strobe, interrupt_ack, irq_event, busy
  );
endinterface

// File: rtl/port_cmd_fifo.sv
// Command queue for the port bus master.
// Ports: clk, reset (sync, active high), push/push_cmd (write side),
// pop/head (read side), avail (a command can be popped this cycle),
// full, empty (registered occupancy flags).
// When empty, head falls through from push_cmd so a command arriving at an
// idle master can be popped in the same cycle it is pushed.
module port_cmd_fifo
  import port_bus_master_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic avail,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign avail   = !empty || push;
  assign head    = empty ? push_cmd : mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && avail;

  // On a fall-through pop both pointers advance together, which keeps the
  // empty queue consistent without a special case.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/port_bus_master.sv
// Port bus master: queues read/write commands and plays them out on a
// strobed port bus, returning read data and acknowledging interrupts.
// Ports: clk, reset (sync, active high), bus (port_bus_master_if.master):
//   req_*      command handshake in, req_ready out
//   rsp_*      read data response (rsp_valid single-cycle pulse)
//   port_id/out_port/in_port and the three strobes to the responder
//   interrupt in, interrupt_ack/irq_event out, busy out
//
// state  | meaning
// IDLE   | wait; service an armed interrupt first, else pop a command
// SETUP  | port_id/out_port driven, no strobe
// STROBE | one strobe for the command; read data sampled at the end
// ACK    | interrupt_ack and irq_event pulse
module port_bus_master
  import port_bus_master_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input logic              clk,
  input logic              reset,
  port_bus_master_if.master bus
);

  state_t     state_q, state_d;
  cmd_t       push_cmd, head;
  logic       push, pop, avail, full, empty;
  logic       armed_q;
  logic       cur_write_q, cur_const_q;
  logic [7:0] port_id_q, out_port_q, rsp_data_q;
  logic       rsp_valid_q;
  logic       rd_stb, wr_stb, k_stb, ack;

  assign push     = bus.req_valid && !full;
  assign push_cmd = '{write: bus.req_write, is_const: bus.req_const,
                      port: bus.req_port, data: bus.req_data};

  port_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .avail    (avail),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rd_stb  = 1'b0;
    wr_stb  = 1'b0;
    k_stb   = 1'b0;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && bus.interrupt) begin
          state_d = ACK;
        end else if (avail) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        rd_stb  = !cur_write_q;
        wr_stb  = cur_write_q && !cur_const_q;
        k_stb   = cur_write_q && cur_const_q;
        state_d = IDLE;
      end
      ACK: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_id_q   <= '0;
      out_port_q  <= '0;
      cur_write_q <= 1'b0;
      cur_const_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      if (pop) begin
        cur_write_q <= head.write;
        cur_const_q <= head.is_const;
        // constant-port writes only reach the low 16 ports
        port_id_q   <= (head.write && head.is_const) ? {4'h0, head.port[3:0]} : head.port;
        out_port_q  <= head.data;
      end
      if (state_q == STROBE && !cur_write_q) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.in_port;
      end
      // re-arm only once the request line has been seen low
      if (!bus.interrupt)                    armed_q <= 1'b1;
      else if (state_q == IDLE && armed_q)   armed_q <= 1'b0;
    end
  end

  assign bus.req_ready      = !full;
  assign bus.port_id        = port_id_q;
  assign bus.out_port       = out_port_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.read_strobe    = rd_stb;
  assign bus.write_strobe   = wr_stb;
  assign bus.k_write_strobe = k_stb;
  assign bus.interrupt_ack  = ack;
  assign bus.irq_event      = ack;
  assign bus.busy           = (state_q != IDLE) || !empty;

endmodule
